// File: rtl/seq_divider_restoring.sv
// -----------------------------------------------------------------------------
// seq_divider_restoring
//   Multi-cycle unsigned restoring divider. One WIDTH-bit trial subtraction
//   per clock: the partial remainder is shifted left by one dividend bit, the
//   divisor is trial-subtracted, and the borrow chooses between the subtracted
//   value (quotient bit 1) and the restored value (quotient bit 0).
//   A divisor of zero is resolved in the start cycle without entering CALC.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled only while idle (busy=0)
//   dividend     unsigned dividend, captured on the accepted start edge
//   divisor      unsigned divisor, captured on the accepted start edge
//   busy         high while a division is iterating (state CALC)
//   done         one-cycle pulse; results are valid from this cycle on
//   quotient     dividend / divisor (all ones on divide-by-zero)
//   remainder    dividend % divisor (dividend on divide-by-zero)
//   div_by_zero  set with done when the captured divisor was zero
// -----------------------------------------------------------------------------
module seq_divider_restoring #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] w_r_reg, w_r_next;     // partial remainder
  logic [WIDTH-1:0] w_q_reg, w_q_next;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvsr_reg, dvsr_next;   // captured divisor
  logic [CW-1:0]    cnt_reg, cnt_next;     // iteration index
  logic [WIDTH-1:0] quot_reg, quot_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic             dbz_reg, dbz_next;
  logic             done_reg, done_next;

  // One restoring step. The partial remainder is always below the divisor,
  // so the shifted value is below 2*divisor and a non-borrowing difference
  // always fits back into WIDTH bits.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] step_r;
  logic [WIDTH-1:0] step_q;

  assign shifted = {w_r_reg, w_q_reg[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvsr_reg};
  assign borrow  = trial[WIDTH];
  assign step_r  = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign step_q  = {w_q_reg[WIDTH-2:0], ~borrow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      w_r_reg   <= '0;
      w_q_reg   <= '0;
      dvsr_reg  <= '0;
      cnt_reg   <= '0;
      quot_reg  <= '0;
      rem_reg   <= '0;
      dbz_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      w_r_reg   <= w_r_next;
      w_q_reg   <= w_q_next;
      dvsr_reg  <= dvsr_next;
      cnt_reg   <= cnt_next;
      quot_reg  <= quot_next;
      rem_reg   <= rem_next;
      dbz_reg   <= dbz_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    w_r_next   = w_r_reg;
    w_q_next   = w_q_reg;
    dvsr_next  = dvsr_reg;
    cnt_next   = cnt_reg;
    quot_next  = quot_reg;
    rem_next   = rem_reg;
    dbz_next   = dbz_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            // Resolved immediately; no iterations are needed.
            done_next = 1'b1;
            dbz_next  = 1'b1;
            quot_next = '1;
            rem_next  = dividend;
          end else begin
            dvsr_next  = divisor;
            w_r_next   = '0;
            w_q_next   = dividend;
            cnt_next   = '0;
            state_next = CALC;
          end
        end
      end

      CALC: begin
        // start is deliberately not looked at here: requests while busy are dropped.
        w_r_next = step_r;
        w_q_next = step_q;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == CW'(WIDTH - 1)) begin
          state_next = IDLE;
          done_next  = 1'b1;
          dbz_next   = 1'b0;
          quot_next  = step_q;
          rem_next   = step_r;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy        = (state_reg == CALC);
  assign done        = done_reg;
  assign quotient    = quot_reg;
  assign remainder   = rem_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider_restoring.sv
// -----------------------------------------------------------------------------
// tb_seq_divider_restoring
//   Directed bench for the 4-bit restoring divider. Inputs change on the
//   falling edge, outputs are sampled on the falling edge, so every value
//   seen belongs to the preceding rising edge. Latency is counted as the
//   number of rising edges after the accepting edge before done is seen.
// -----------------------------------------------------------------------------
module tb_seq_divider_restoring;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int tests = 0;
  int fails = 0;

  seq_divider_restoring #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present a request for one cycle; returns at the falling edge after the accepting edge.
  task automatic issue(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Wait (bounded) for done, counting rising edges from lat0.
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Full transaction against the arithmetic operators as the reference.
  task automatic run_case(input logic [3:0] a, input logic [3:0] b);
    int lat;
    logic [3:0] eq, er;
    logic ez;
    int elat;
    if (b == 4'd0) begin
      eq = 4'hF; er = a; ez = 1'b1; elat = 0;
    end else begin
      eq = a / b; er = a % b; ez = 1'b0; elat = 4;
    end
    issue(a, b);
    wait_done(0, lat);
    chk("latency", 16'(lat), 16'(elat));
    chk("quotient", 16'(quotient), 16'(eq));
    chk("remainder", 16'(remainder), 16'(er));
    chk("div_by_zero", 16'(div_by_zero), 16'(ez));
    $display("[TB] %0d/%0d -> q=%0d r=%0d dbz=%0b lat=%0d", a, b, quotient, remainder, div_by_zero, lat);
  endtask

  initial begin
    int lat;
    int seen;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_quot", 16'(quotient), 16'd0);
    chk("rst_rem", 16'(remainder), 16'd0);
    chk("rst_dbz", 16'(div_by_zero), 16'd0);
    rst_n = 1'b1;

    // ---- 13/3: busy for 4 cycles, done at the 4th edge after acceptance ----
    issue(4'd13, 4'd3);
    chk("t1_busy0", 16'(busy), 16'd1);
    chk("t1_done0", 16'(done), 16'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("t1_busy_mid", 16'(busy), 16'd1);
      chk("t1_done_mid", 16'(done), 16'd0);
    end
    @(negedge clk);
    chk("t1_done", 16'(done), 16'd1);
    chk("t1_busy_end", 16'(busy), 16'd0);
    chk("t1_quot", 16'(quotient), 16'd4);
    chk("t1_rem", 16'(remainder), 16'd1);
    chk("t1_dbz", 16'(div_by_zero), 16'd0);
    @(negedge clk);
    chk("t1_done_pulse", 16'(done), 16'd0);
    chk("t1_quot_hold", 16'(quotient), 16'd4);
    $display("[TB] 13/3 -> q=%0d r=%0d", quotient, remainder);

    // ---- assorted quotients including boundaries ----
    run_case(4'd15, 4'd15);
    run_case(4'd6, 4'd7);
    run_case(4'd0, 4'd5);
    run_case(4'd15, 4'd1);

    // ---- divide by zero: resolved on the accepting edge, never busy ----
    issue(4'd9, 4'd0);
    chk("t3_busy", 16'(busy), 16'd0);
    chk("t3_done", 16'(done), 16'd1);
    chk("t3_quot", 16'(quotient), 16'hF);
    chk("t3_rem", 16'(remainder), 16'd9);
    chk("t3_dbz", 16'(div_by_zero), 16'd1);
    @(negedge clk);
    chk("t3_done_pulse", 16'(done), 16'd0);
    chk("t3_busy_after", 16'(busy), 16'd0);
    chk("t3_dbz_hold", 16'(div_by_zero), 16'd1);
    $display("[TB] 9/0 -> q=%0h r=%0d dbz=%0b", quotient, remainder, div_by_zero);

    // ---- start while busy is ignored; old results held during CALC ----
    issue(4'd13, 4'd3);
    @(negedge clk);
    start = 1'b1; dividend = 4'd8; divisor = 4'd2;
    @(negedge clk);
    start = 1'b0;
    chk("t4_busy", 16'(busy), 16'd1);
    chk("t4_hold_quot", 16'(quotient), 16'hF);
    chk("t4_hold_rem", 16'(remainder), 16'd9);
    chk("t4_hold_dbz", 16'(div_by_zero), 16'd1);
    wait_done(2, lat);
    chk("t4_latency", 16'(lat), 16'd4);
    chk("t4_quot", 16'(quotient), 16'd4);
    chk("t4_rem", 16'(remainder), 16'd1);
    chk("t4_dbz", 16'(div_by_zero), 16'd0);
    @(negedge clk);
    chk("t4_no_second_done", 16'(done), 16'd0);
    chk("t4_idle", 16'(busy), 16'd0);
    $display("[TB] 13/3 with ignored 8/2 -> q=%0d r=%0d", quotient, remainder);

    // ---- asynchronous reset mid-CALC ----
    issue(4'd13, 4'd3);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", 16'(busy), 16'd0);
    chk("t5_done", 16'(done), 16'd0);
    chk("t5_quot", 16'(quotient), 16'd0);
    chk("t5_rem", 16'(remainder), 16'd0);
    chk("t5_dbz", 16'(div_by_zero), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    chk("t5_no_done", 16'(seen), 16'd0);
    $display("[TB] reset mid-CALC, activity after release=%0d", seen);
    run_case(4'd8, 4'd2);

    // ---- back-to-back: new start in the done cycle ----
    issue(4'd13, 4'd3);
    wait_done(0, lat);
    chk("t6_lat1", 16'(lat), 16'd4);
    chk("t6_quot1", 16'(quotient), 16'd4);
    chk("t6_rem1", 16'(remainder), 16'd1);
    start = 1'b1; dividend = 4'd14; divisor = 4'd4;
    @(negedge clk);
    start = 1'b0;
    chk("t6_busy", 16'(busy), 16'd1);
    chk("t6_done_gap", 16'(done), 16'd0);
    wait_done(0, lat);
    chk("t6_lat2", 16'(lat), 16'd4);
    chk("t6_quot2", 16'(quotient), 16'd3);
    chk("t6_rem2", 16'(remainder), 16'd2);
    $display("[TB] 13/3 then 14/4 -> q=%0d r=%0d", quotient, remainder);

    // ---- exhaustive 4-bit sweep ----
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_case(4'(a), 4'(b));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
